// File: rtl/rx_wr_space_ctrl_pkg.sv
// Shared defaults and FSM encoding for the RX write-side space controller.
`ifndef RX_BUF_AW
`define RX_BUF_AW 10
`endif

package rx_wr_space_ctrl_pkg;

  // Buffer address width in 64-bit words, tied to the buffer-width define.
  localparam int unsigned RX_AW_DEFAULT              = `RX_BUF_AW;
  // Worst-case frame length and guard band, in words.
  localparam int unsigned RX_MAX_FRAME_WORDS_DEFAULT = 191;
  localparam int unsigned RX_MARGIN_WORDS_DEFAULT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_WRITE  = 2'd2,
    ST_COMMIT = 2'd3
  } wr_state_e;

endpackage

// File: rtl/rx_free_space_calc.sv
// Registered free-space calculation: (2^AW-1) - ((wr - rd) mod 2^AW).
// One word is kept unused so that full and empty stay distinguishable.
import rx_wr_space_ctrl_pkg::*;

module rx_free_space_calc #(
  parameter int unsigned AW = RX_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] wr_ptr_i,
  input  logic [AW-1:0] rd_ptr_i,
  output logic [AW-1:0] free_words_o
);

  logic [AW-1:0] used_s;
  logic [AW-1:0] free_d;
  logic [AW-1:0] free_q;

  // Modular occupancy and its complement against the usable depth.
  always_comb begin
    used_s = wr_ptr_i - rd_ptr_i;
    free_d = {AW{1'b1}} - used_s;
  end

  // Free-space register; an empty buffer after reset reports full usable depth.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      free_q <= {AW{1'b1}};
    end else begin
      free_q <= free_d;
    end
  end

  assign free_words_o = free_q;

endmodule

// File: rtl/rx_wr_space_ctrl.sv
// Write-side admission and pointer controller for the RX host buffer.
// Admits a frame only if a worst-case frame plus guard band fits, tracks the
// write pointer, and commits it at frame end or rewinds it on drop/oversize.
import rx_wr_space_ctrl_pkg::*;

module rx_wr_space_ctrl #(
  parameter int unsigned AW              = RX_AW_DEFAULT,
  parameter int unsigned MAX_FRAME_WORDS = RX_MAX_FRAME_WORDS_DEFAULT,
  parameter int unsigned MARGIN_WORDS    = RX_MARGIN_WORDS_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] commited_rd_address,
  input  logic          frame_req,
  output logic          frame_grant,
  output logic          frame_refused,
  input  logic          wr_valid,
  input  logic          frame_end,
  input  logic          frame_drop,
  output logic [AW-1:0] wr_address,
  output logic [AW-1:0] commited_wr_address,
  output logic [AW-1:0] free_words,
  output logic          oversize,
  output logic [31:0]   refused_cnt,
  output logic          buffer_empty
);

  // Counter must hold MAX_FRAME_WORDS+1 (a frame_end arriving on the last allowed slot).
  localparam int unsigned CW        = $clog2(MAX_FRAME_WORDS + 2);
  localparam int unsigned THRESH    = MAX_FRAME_WORDS + MARGIN_WORDS;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_FRAME_WORDS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  wr_state_e     state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] cwr_addr_q, cwr_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_q, grant_d;
  logic          refused_q, refused_d;
  logic          oversize_q, oversize_d;
  logic [31:0]   refused_cnt_q, refused_cnt_d;
  logic          empty_q, empty_d;
  logic [AW-1:0] free_words_s;

  rx_free_space_calc #(
    .AW (AW)
  ) u_free_space (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_ptr_i     (wr_addr_q),
    .rd_ptr_i     (commited_rd_address),
    .free_words_o (free_words_s)
  );

  // Next-state and pulse generation for the admission/write FSM.
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    cwr_addr_d    = cwr_addr_q;
    cnt_d         = cnt_q;
    grant_d       = 1'b0;
    refused_d     = 1'b0;
    oversize_d    = 1'b0;
    refused_cnt_d = refused_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_req) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        // Decision uses the registered free space; a stale read pointer only under-reports.
        if (32'(free_words_s) >= THRESH) begin
          grant_d = 1'b1;
          cnt_d   = {CW{1'b0}};
          state_d = ST_WRITE;
        end else begin
          refused_d = 1'b1;
          if (refused_cnt_q != 32'hFFFF_FFFF) begin
            refused_cnt_d = refused_cnt_q + 32'd1;
          end else begin
            refused_cnt_d = refused_cnt_q;
          end
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (frame_drop) begin
          // Drop beats any word or end marker in the same cycle.
          wr_addr_d = cwr_addr_q;
          state_d   = ST_IDLE;
        end else if (wr_valid) begin
          if (frame_end) begin
            wr_addr_d = wr_addr_q + PTR_ONE;
            cnt_d     = cnt_q + CNT_ONE;
            state_d   = ST_COMMIT;
          end else if (cnt_q == MAX_CNT) begin
            wr_addr_d  = cwr_addr_q;
            oversize_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            wr_addr_d = wr_addr_q + PTR_ONE;
            cnt_d     = cnt_q + CNT_ONE;
            state_d   = ST_WRITE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_COMMIT: begin
        cwr_addr_d = wr_addr_q;
        state_d    = ST_IDLE;
      end
      default: begin
        wr_addr_d = cwr_addr_q;
        state_d   = ST_IDLE;
      end
    endcase

    empty_d = (cwr_addr_d == commited_rd_address) && (state_d == ST_IDLE);
  end

  // State, pointer and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wr_addr_q     <= {AW{1'b0}};
      cwr_addr_q    <= {AW{1'b0}};
      cnt_q         <= {CW{1'b0}};
      grant_q       <= 1'b0;
      refused_q     <= 1'b0;
      oversize_q    <= 1'b0;
      refused_cnt_q <= 32'd0;
      empty_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      cwr_addr_q    <= cwr_addr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      refused_q     <= refused_d;
      oversize_q    <= oversize_d;
      refused_cnt_q <= refused_cnt_d;
      empty_q       <= empty_d;
    end
  end

  assign frame_grant         = grant_q;
  assign frame_refused       = refused_q;
  assign oversize            = oversize_q;
  assign wr_address          = wr_addr_q;
  assign commited_wr_address = cwr_addr_q;
  assign free_words          = free_words_s;
  assign refused_cnt         = refused_cnt_q;
  assign buffer_empty        = empty_q;

endmodule

// File: tb/tb_rx_wr_space_ctrl.sv
// Self-checking bench for rx_wr_space_ctrl: directed scenarios followed by
// randomized frames, checked against a frame-level model of the buffer.
module tb_rx_wr_space_ctrl;

  localparam int AW    = 10;
  localparam int MAXW  = 191;
  localparam int MARG  = 4;
  localparam int DEPTH = 1 << AW;
  localparam int MASK  = DEPTH - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rd;
  logic          frame_req, frame_grant, frame_refused;
  logic          wr_valid, frame_end, frame_drop;
  logic [AW-1:0] wr_address, cwr, free_words;
  logic          oversize;
  logic [31:0]   refused_cnt;
  logic          buffer_empty;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level model: committed pointers and refusal count.
  int m_cwr = 0;
  int m_rd  = 0;
  int m_refused = 0;

  always #5 clk = ~clk;

  rx_wr_space_ctrl #(.AW(AW), .MAX_FRAME_WORDS(MAXW), .MARGIN_WORDS(MARG)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .commited_rd_address (rd),
    .frame_req           (frame_req),
    .frame_grant         (frame_grant),
    .frame_refused       (frame_refused),
    .wr_valid            (wr_valid),
    .frame_end           (frame_end),
    .frame_drop          (frame_drop),
    .wr_address          (wr_address),
    .commited_wr_address (cwr),
    .free_words          (free_words),
    .oversize            (oversize),
    .refused_cnt         (refused_cnt),
    .buffer_empty        (buffer_empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_free();
    return (DEPTH - 1) - ((m_cwr - m_rd) & MASK);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with junk on the write strobes, which must be ignored outside WRITE.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      frame_req  = 1'b0;
      wr_valid   = 1'($urandom);
      frame_end  = 1'($urandom);
      frame_drop = 1'($urandom);
      step();
    end
    wr_valid = 1'b0; frame_end = 1'b0; frame_drop = 1'b0;
  endtask

  task automatic check_idle();
    chk("wr_address",   wr_address,   64'(m_cwr));
    chk("commited_wr",  cwr,          64'(m_cwr));
    chk("free_words",   free_words,   64'(m_free()));
    chk("refused_cnt",  refused_cnt,  64'(m_refused));
    chk("buffer_empty", buffer_empty, 64'(m_cwr == m_rd));
  endtask

  task automatic set_rd(input int v);
    m_rd = v & MASK;
    rd   = AW'(m_rd);
    idle(2);
  endtask

  // mode: 0 commit n words, 1 drop after n words, 2 oversize,
  //       3 reset after n words, 4 drop with wr_valid+frame_end in the drop cycle.
  task automatic do_frame(input int n_in, input int mode);
    int  n;
    int  exp_wr;
    bit  exp_grant;
    bit  last_ovs;
    n = (mode == 2) ? MAXW + 1 : n_in;
    exp_grant = (m_free() >= MAXW + MARG);
    frame_req = 1'b1; wr_valid = 1'b0; frame_end = 1'b0; frame_drop = 1'b0;
    step();
    frame_req = 1'b0;
    chk("grant_early",   frame_grant,   64'(0));
    chk("refused_early", frame_refused, 64'(0));
    step();
    chk("frame_grant",   frame_grant,   64'(exp_grant));
    chk("frame_refused", frame_refused, 64'(!exp_grant));
    if (!exp_grant) begin
      m_refused++;
      idle(2);
      check_idle();
      return;
    end
    for (int i = 1; i <= n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        wr_valid = 1'b0; frame_end = 1'b0; frame_drop = 1'b0;
        step();
      end
      wr_valid   = 1'b1;
      frame_end  = (mode == 0) && (i == n);
      frame_drop = 1'b0;
      step();
      if (i == 1) chk("grant_pulse", frame_grant, 64'(0));
      last_ovs = (mode == 2) && (i == n);
      exp_wr   = last_ovs ? m_cwr : ((m_cwr + i) & MASK);
      chk("oversize",   oversize,   64'(last_ovs));
      chk("wr_advance", wr_address, 64'(exp_wr));
    end
    wr_valid = 1'b0; frame_end = 1'b0;
    if (mode == 1 || mode == 4) begin
      frame_drop = 1'b1;
      wr_valid   = (mode == 4) ? 1'b1 : 1'($urandom);
      frame_end  = (mode == 4) ? 1'b1 : 1'($urandom);
      step();
      frame_drop = 1'b0; wr_valid = 1'b0; frame_end = 1'b0;
      chk("drop_rewind", wr_address, 64'(m_cwr));
      chk("drop_cwr",    cwr,        64'(m_cwr));
    end else if (mode == 3) begin
      reset_n = 1'b0;
      rd      = '0;
      step();
      reset_n = 1'b1;
      m_cwr = 0; m_rd = 0; m_refused = 0;
    end else if (mode == 0) begin
      step();
      m_cwr = (m_cwr + n) & MASK;
      chk("commit_cwr", cwr, 64'(m_cwr));
    end
    idle(2);
    check_idle();
  endtask

  initial begin
    reset_n = 1'b0; rd = '0; frame_req = 1'b0;
    wr_valid = 1'b0; frame_end = 1'b0; frame_drop = 1'b0;
    repeat (3) step();
    chk("rst_wr",          wr_address,    64'(0));
    chk("rst_cwr",         cwr,           64'(0));
    chk("rst_grant",       frame_grant,   64'(0));
    chk("rst_refused",     frame_refused, 64'(0));
    chk("rst_oversize",    oversize,      64'(0));
    chk("rst_refused_cnt", refused_cnt,   64'(0));
    chk("rst_free",        free_words,    64'(1023));
    chk("rst_empty",       buffer_empty,  64'(1));
    reset_n = 1'b1;
    idle(3);
    check_idle();

    // Single 100-word frame from empty.
    do_frame(100, 0);
    chk("free_after_100", free_words, 64'(923));
    // Fill to 830 with rd at 0: free 193 is refused, free 203 is granted.
    do_frame(191, 0); do_frame(191, 0); do_frame(191, 0); do_frame(157, 0);
    chk("cwr_830", cwr, 64'(830));
    do_frame(10, 0);
    chk("refused_once", refused_cnt, 64'(1));
    set_rd(10);
    do_frame(10, 0);
    chk("cwr_840", cwr, 64'(840));
    // Drop after 50 words.
    do_frame(50, 1);
    // Wrap: rd and committed pointer at 1000, then a 100-word frame.
    set_rd(840);
    do_frame(160, 0);
    set_rd(1000);
    do_frame(100, 0);
    chk("wrap_cwr",  cwr,        64'(76));
    chk("wrap_free", free_words, 64'(923));
    // Oversize, then drop colliding with frame_end.
    do_frame(0, 2);
    do_frame(30, 4);
    // Reset in the middle of a frame.
    do_frame(20, 3);

    // Randomized frames with random host read progress.
    for (int it = 0; it < 40; it++) begin
      int r;
      if ($urandom_range(0, 1) == 1)
        set_rd(m_rd + $urandom_range(0, (m_cwr - m_rd) & MASK));
      r = $urandom_range(0, 9);
      if (r <= 5 || r == 9) do_frame($urandom_range(1, MAXW), 0);
      else if (r <= 7)      do_frame($urandom_range(0, MAXW - 1), 1);
      else                  do_frame(0, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
